// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO writes
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   start_i, op_i       issue request and opcode, sampled only while idle
//   src_a_i, src_b_i    rs / rt operands
//   flush_i             abort an in-flight mult/div without touching HI/LO
//   busy_o, done_o      unit busy, one-cycle result-written pulse
//   hi_o, lo_o          HI / LO result registers
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_m, r_hi, r_lo;
    logic                 r_div, r_neg_q, r_neg_r, r_div0, r_done;
    logic                 w_neg_a, w_neg_b;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b, w_q, w_r, w_fix_hi, w_fix_lo;
    logic [WIDTH:0]       w_sum, w_rem, w_diff;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_mul_next, w_div_next, w_prod;
    assign w_neg_a = ~op_i[0] & src_a_i[WIDTH-1];
    assign w_neg_b = ~op_i[0] & src_b_i[WIDTH-1];
    assign w_abs_a = w_neg_a ? -src_a_i : src_a_i;
    assign w_abs_b = w_neg_b ? -src_b_i : src_b_i;
    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_acc[0] ? r_m : '0};
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
    // Divide: restoring step on the left-shifted partial remainder; a zero divisor always
    // "fits", which leaves the dividend in the remainder and all ones in the quotient
    assign w_rem      = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_rem - {1'b0, r_m};
    assign w_ge       = r_div0 | ~w_diff[WIDTH];
    assign w_div_next = {w_ge ? w_diff[WIDTH-1:0] : w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge};
    assign w_prod   = r_neg_q ? -r_acc : r_acc;
    assign w_q      = r_acc[WIDTH-1:0];
    assign w_r      = r_acc[2*WIDTH-1:WIDTH];
    assign w_fix_hi = r_div ? (r_neg_r ? -w_r : w_r) : w_prod[2*WIDTH-1:WIDTH];
    assign w_fix_lo = r_div ? (r_div0 ? '1 : r_neg_q ? -w_q : w_q) : w_prod[WIDTH-1:0];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_m     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i && !op_i[2]) begin
                        r_state <= CALC;
                        r_cnt   <= '0;
                        r_div   <= op_i[1];
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_div0  <= op_i[1] && (src_b_i == '0);
                        r_m     <= op_i[1] ? w_abs_b : w_abs_a;
                        r_acc   <= {{WIDTH{1'b0}}, op_i[1] ? w_abs_a : w_abs_b};
                    end else if (start_i && !op_i[1]) begin
                        if (op_i[0]) r_lo <= src_a_i;
                        else         r_hi <= src_a_i;
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc <= r_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    if (!flush_i) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy_o = (r_state != IDLE);
    assign done_o = r_done;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed checks of mul_div_unit at WIDTH=32 and WIDTH=8
module tb_mul_div_unit;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0, flush = 0;
    logic [2:0]  op = 0;
    logic [31:0] sa = 0, sb = 0;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic        s8_start = 0;
    logic [2:0]  s8_op = 0;
    logic [7:0]  s8_a = 0, s8_b = 0;
    logic        s8_busy, s8_done;
    logic [7:0]  s8_hi, s8_lo;
    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .src_a_i(sa), .src_b_i(sb),
        .flush_i(flush), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    mul_div_unit #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(s8_start), .op_i(s8_op), .src_a_i(s8_a), .src_b_i(s8_b),
        .flush_i(1'b0), .busy_o(s8_busy), .done_o(s8_done), .hi_o(s8_hi), .lo_o(s8_lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues op, optionally pokes start mid-operation, ends in the done cycle
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int poke);
        int n;
        int dn;
        start = 1; op = o; sa = a; sb = b;
        @(negedge clk);
        start = 0; flush = 0; op = 3'b001; sa = 32'h1; sb = 32'h1;
        n = 0; dn = 0;
        while (busy && n < 100) begin
            start = (n == poke);
            if (done) dn++;
            n++;
            @(negedge clk);
        end
        start = 0;
        chk({tag, ".busy_cycles"}, 64'(n), 64'd33);
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".early_done"}, 64'(dn), 64'd0);
        chk({tag, ".hi"}, 64'(hi), 64'(ehi));
        chk({tag, ".lo"}, 64'(lo), 64'(elo));
    endtask

    task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ehi, input logic [7:0] elo);
        int n;
        s8_start = 1; s8_op = o; s8_a = a; s8_b = b;
        @(negedge clk);
        s8_start = 0; s8_a = 8'h1; s8_b = 8'h1;
        n = 0;
        while (s8_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, 64'(n), 64'd9);
        chk({tag, ".done"}, 64'(s8_done), 64'd1);
        chk({tag, ".hi"}, 64'(s8_hi), 64'(ehi));
        chk({tag, ".lo"}, 64'(s8_lo), 64'(elo));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        chk("rst8.busy", 64'(s8_busy), 64'd0);

        run("mult_neg", 3'b000, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, -1);
        @(negedge clk);
        chk("mult_neg.single_done", 64'(done), 64'd0);

        run("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, -1);
        run("div_b2b", 3'b010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
        run("divu_zero", 3'b011, 32'h64, 32'h0, 32'h64, 32'hFFFFFFFF, -1);
        run("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, -1);
        run("div_zero_neg", 3'b010, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, -1);
        run("div_pos_neg", 3'b010, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, -1);
        run("div_neg_neg", 3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h3, -1);
        run("mult_min", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, -1);
        @(negedge clk);

        start = 1; op = 3'b100; sa = 32'h12345678;
        @(negedge clk);
        chk("mthi.hi", 64'(hi), 64'h12345678);
        chk("mthi.busy", 64'(busy), 64'd0);
        op = 3'b101; sa = 32'h9ABCDEF0;
        @(negedge clk);
        chk("mtlo.lo", 64'(lo), 64'h9ABCDEF0);
        chk("mtlo.hi", 64'(hi), 64'h12345678);
        chk("mtlo.busy", 64'(busy), 64'd0);
        op = 3'b110; sa = 32'hDEADBEEF;
        @(negedge clk);
        chk("rsvd.busy", 64'(busy), 64'd0);
        chk("rsvd.hi", 64'(hi), 64'h12345678);
        chk("rsvd.lo", 64'(lo), 64'h9ABCDEF0);

        op = 3'b000; sa = 32'h3; sb = 32'h4;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_calc.busy", 64'(busy), 64'd0);
        chk("flush_calc.done", 64'(done), 64'd0);
        chk("flush_calc.hi", 64'(hi), 64'h12345678);
        chk("flush_calc.lo", 64'(lo), 64'h9ABCDEF0);
        @(negedge clk);
        chk("flush_calc.done_late", 64'(done), 64'd0);

        start = 1; op = 3'b000; sa = 32'h3; sb = 32'h4;
        @(negedge clk);
        start = 0;
        repeat (32) @(negedge clk);
        chk("flush_fix.busy_before", 64'(busy), 64'd1);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_fix.busy", 64'(busy), 64'd0);
        chk("flush_fix.done", 64'(done), 64'd0);
        chk("flush_fix.hi", 64'(hi), 64'h12345678);
        chk("flush_fix.lo", 64'(lo), 64'h9ABCDEF0);

        flush = 1;
        run("idle_flush", 3'b001, 32'h2, 32'h3, 32'h0, 32'h6, -1);
        run("busy_start", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 5);
        @(negedge clk);

        start = 1; op = 3'b011; sa = 32'd100; sb = 32'd7;
        @(negedge clk);
        start = 0;
        repeat (19) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid.busy", 64'(busy), 64'd0);
        chk("rst_mid.hi", 64'(hi), 64'd0);
        chk("rst_mid.lo", 64'(lo), 64'd0);
        @(negedge clk);
        chk("rst_mid.done", 64'(done), 64'd0);

        run8("w8_mult", 3'b000, 8'h80, 8'h80, 8'h40, 8'h00);
        run8("w8_div_ovf", 3'b010, 8'h80, 8'hFF, 8'h00, 8'h80);
        run8("w8_divu_zero", 3'b011, 8'hF9, 8'h00, 8'hF9, 8'hFF);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
